// File: rtl/jpeg_stream_pkg.sv
// jpeg_stream_reader shared definitions.
// FSM states, EOI marker, tile size and parameter legality check.
package jpeg_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_JED,
    S_DRAIN
  } state_t;

  localparam logic [15:0] EOI_MARK = 16'hFFD9;
  localparam int TILE = 8;

  function automatic bit params_ok(
    input int hdr_size,
    input int hdr_aw,
    input int je_aw,
    input int img_w,
    input int img_h,
    input int bpp,
    input int rd_lat,
    input int buf_depth
  );
    longint hdr_span;
    longint je_span;
    longint img_bytes;
    hdr_span = longint'(1) << hdr_aw;
    je_span = longint'(1) << je_aw;
    img_bytes = longint'(img_w) * longint'(img_h) * longint'(bpp);
    return (rd_lat == 1 || rd_lat == 2) &&
           (buf_depth >= rd_lat + 2) &&
           (hdr_size >= 1) && (img_w >= 1) &&
           (img_h >= 1) && (bpp >= 1) &&
           (longint'(hdr_size) <= hdr_span) &&
           (img_bytes <= je_span);
  endfunction

endpackage

// File: rtl/jpeg_tile_addr_gen.sv
// Payload address counter, 8x8-tiled or linear order.
// Address is registered; advance consumes it, addr_last marks the final one.
module jpeg_tile_addr_gen
  import jpeg_stream_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 200,
  parameter int BPP   = 2,
  parameter int TILED = 1,
  parameter int JE_AW = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic             addr_valid,
  output logic [JE_AW-1:0] addr,
  output logic             addr_last
);

  localparam int TW = (TILED != 0) ? TILE : IMG_W;
  localparam int TH = (TILED != 0) ? TILE : IMG_H;
  localparam int CW = $clog2(IMG_W + TW + 1);
  localparam int RW = $clog2(IMG_H + TH + 1);
  localparam int BW = (BPP > 1) ? $clog2(BPP) : 1;

  logic [CW-1:0]    col, tx0, tx_nxt;
  logic [RW-1:0]    row, ty0, ty_nxt;
  logic [BW-1:0]    b;
  logic             live, load;
  logic             b_end, col_end, row_end;
  logic             tx_end, ty_end, all_end;
  logic [JE_AW-1:0] addr_c;

  // loop-end detection and address arithmetic for the current position
  always_comb begin
    tx_nxt  = tx0 + CW'(TW);
    ty_nxt  = ty0 + RW'(TH);
    b_end   = (b == BW'(BPP - 1));
    col_end = (col == CW'(IMG_W - 1)) ||
              (col == tx_nxt - CW'(1));
    row_end = (row == RW'(IMG_H - 1)) ||
              (row == ty_nxt - RW'(1));
    tx_end  = (tx_nxt >= CW'(IMG_W));
    ty_end  = (ty_nxt >= RW'(IMG_H));
    all_end = b_end && col_end && row_end &&
              tx_end && ty_end;
    addr_c  = (JE_AW'(row) * JE_AW'(IMG_W) +
               JE_AW'(col)) * JE_AW'(BPP) +
              JE_AW'(b);
    load    = live && (!addr_valid || advance);
  end

  // step the nested loops and register the product one cycle ahead of use
  always_ff @(posedge clk) begin
    if (reset) begin
      b          <= '0;
      col        <= '0;
      row        <= '0;
      tx0        <= '0;
      ty0        <= '0;
      live       <= 1'b0;
      addr_valid <= 1'b0;
      addr       <= '0;
      addr_last  <= 1'b0;
    end else if (clear) begin
      b          <= '0;
      col        <= '0;
      row        <= '0;
      tx0        <= '0;
      ty0        <= '0;
      live       <= 1'b1;
      addr_valid <= 1'b0;
      addr_last  <= 1'b0;
    end else if (load) begin
      addr       <= addr_c;
      addr_last  <= all_end;
      addr_valid <= 1'b1;
      if (all_end) live <= 1'b0;
      if (!b_end) begin
        b <= b + BW'(1);
      end else begin
        b <= '0;
        if (!col_end) begin
          col <= col + CW'(1);
        end else if (!row_end) begin
          col <= tx0;
          row <= row + RW'(1);
        end else if (!tx_end) begin
          tx0 <= tx_nxt;
          col <= tx_nxt;
          row <= ty0;
        end else begin
          tx0 <= '0;
          col <= '0;
          ty0 <= ty_nxt;
          row <= ty_nxt;
        end
      end
    end else if (advance) begin
      addr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/jpeg_stream_reader.sv
// Header ROM + entropy payload to valid/ready byte stream.
// Optional STREAM_LEN_EN adds the stream_len byte-count output.
module jpeg_stream_reader
  import jpeg_stream_pkg::*;
#(
  parameter int HDR_SIZE  = 607,
  parameter int HDR_AW    = 10,
  parameter int JE_AW     = 17,
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 200,
  parameter int BPP       = 2,
  parameter int TILED     = 1,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_overrun,
  output logic [HDR_AW-1:0] hd_addr,
  input  logic [7:0]        hd_data,
  output logic [JE_AW-1:0]  je_addr,
  input  logic [7:0]        je_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef STREAM_LEN_EN
  ,
  output logic [HDR_AW+JE_AW-1:0] stream_len
`endif
);

  localparam bit PARAMS_OK = params_ok(HDR_SIZE,
    HDR_AW, JE_AW, IMG_W, IMG_H, BPP, RD_LAT,
    BUF_DEPTH);

  if (!PARAMS_OK) begin : g_bad_params
    $error("jpeg_stream_reader: illegal parameters");
  end

  localparam int PW   = $clog2(BUF_DEPTH);
  localparam int CNTW = $clog2(BUF_DEPTH + 1);
  localparam int FW   = $clog2(2 * BUF_DEPTH + 1);

  state_t              state, state_nxt;
  logic [RD_LAT-1:0]   pv, ph, pl;
  logic [7:0]          mem_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] mem_l;
  logic [PW-1:0]       rp, wp;
  logic [CNTW-1:0]     cnt;
  logic [FW-1:0]       inflight;
  logic [15:0]         sr;
  logic                ended;
  logic                ga_valid, ga_last;
  logic                accept, can_issue;
  logic                hd_issue, je_issue;
  logic                ret_v, ret_h, ret_l;
  logic [7:0]          ret_d;
  logic                push, pop, eoi_now, push_last;

  jpeg_tile_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .BPP   (BPP),
    .TILED (TILED),
    .JE_AW (JE_AW)
  ) u_addr (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .advance    (je_issue),
    .addr_valid (ga_valid),
    .addr       (je_addr),
    .addr_last  (ga_last)
  );

  // issue gating, return decode, EOI match and buffer head
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + FW'(pv[i]);
    ret_v     = pv[RD_LAT-1];
    ret_h     = ph[RD_LAT-1];
    ret_l     = pl[RD_LAT-1];
    ret_d     = ret_h ? hd_data : je_data;
    push      = ret_v && !ended;
    eoi_now   = push && !ret_h &&
                ({sr[7:0], je_data} == EOI_MARK);
    push_last = eoi_now || (push && !ret_h && ret_l);
    can_issue = (FW'(cnt) + inflight) <
                FW'(BUF_DEPTH);
    accept    = (state == S_IDLE) && start;
    hd_issue  = (state == S_HDR) && can_issue;
    je_issue  = (state == S_JED) && can_issue &&
                ga_valid && !eoi_now && !ended;
    out_valid = (cnt != '0);
    out_data  = out_valid ? mem_d[rp] : 8'h00;
    out_last  = out_valid && mem_l[rp];
    pop       = out_valid && out_ready;
    busy      = (state != S_IDLE);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state and done pulse
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      S_IDLE:
        if (start) state_nxt = S_HDR;
      S_HDR:
        if (hd_issue &&
            hd_addr == HDR_AW'(HDR_SIZE - 1))
          state_nxt = S_JED;
      S_JED:
        if (push_last || (je_issue && ga_last))
          state_nxt = S_DRAIN;
      S_DRAIN:
        if (pop && out_last) begin
          state_nxt = S_IDLE;
          done      = 1'b1;
        end
      default: state_nxt = S_IDLE;
    endcase
  end

  // read pipeline, buffer pointers, EOI history and overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pv          <= '0;
      ph          <= '0;
      pl          <= '0;
      rp          <= '0;
      wp          <= '0;
      cnt         <= '0;
      sr          <= '0;
      ended       <= 1'b0;
      hd_addr     <= '0;
      err_overrun <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        ph[i] <= ph[i-1];
        pl[i] <= pl[i-1];
      end
      pv[0] <= hd_issue || je_issue;
      ph[0] <= hd_issue;
      pl[0] <= je_issue && ga_last;
      if (push)
        wp <= (wp == PW'(BUF_DEPTH - 1)) ?
              '0 : wp + PW'(1);
      if (pop)
        rp <= (rp == PW'(BUF_DEPTH - 1)) ?
              '0 : rp + PW'(1);
      cnt <= cnt + CNTW'(push) - CNTW'(pop);
      if (push && !ret_h) sr <= {sr[7:0], je_data};
      if (push_last) ended <= 1'b1;
      if (push_last && !eoi_now) err_overrun <= 1'b1;
      if (hd_issue &&
          hd_addr != HDR_AW'(HDR_SIZE - 1))
        hd_addr <= hd_addr + HDR_AW'(1);
      if (accept) begin
        pv          <= '0;
        hd_addr     <= '0;
        sr          <= '0;
        ended       <= 1'b0;
        err_overrun <= 1'b0;
      end
    end
  end

  // buffer storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wp] <= ret_d;
      mem_l[wp] <= push_last;
    end
  end

`ifdef STREAM_LEN_EN
  logic [HDR_AW+JE_AW-1:0] acc_cnt;

  // count accepted bytes and latch the total on done
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt    <= '0;
      stream_len <= '0;
    end else begin
      if (accept)   acc_cnt <= '0;
      else if (pop) acc_cnt <= acc_cnt + 1'b1;
      if (done)     stream_len <= acc_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/jpeg_stream_reader.md
Name: jpeg_stream_reader

Overview:
Parametrised successor of the JPEG-to-SPI glue. After the encoder finishes, this block reads the JFIF header ROM and then the encoder's entropy-coded byte memory, and presents the result as one byte stream on a valid/ready interface. That interface feeds the SPI slave or any other byte sink. Image geometry, bytes per pixel, memory read latency and payload addressing order (8x8-tiled or linear) are all parameters. Backpressure is handled by a small prefetch buffer.

Parameters:
HDR_SIZE, 607, header bytes read from header ROM, addresses 0..HDR_SIZE-1
HDR_AW, 10, header ROM address width
JE_AW, 17, payload memory address width
IMG_W, 320, image width in pixels
IMG_H, 200, image height in pixels
BPP, 2, bytes per pixel
TILED, 1, 1 = 8x8 block-order addressing; 0 = linear addressing
RD_LAT, 1, memory read latency in cycles (1 or 2), identical for both memories
BUF_DEPTH, 4, output buffer entries; must be at least RD_LAT+2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  encoder done pulse; starts a stream when idle
busy  out  1  stream in progress
done  out  1  one-cycle pulse when the last byte is accepted
err_overrun  out  1  sticky flag: payload exhausted without EOI; cleared by the next accepted start
hd_addr  out  HDR_AW  header ROM address
hd_data  in  8  header ROM data, valid RD_LAT cycles after hd_addr
je_addr  out  JE_AW  payload memory address
je_data  in  8  payload data, valid RD_LAT cycles after je_addr
out_data  out  8  stream byte
out_valid  out  1  out_data is valid
out_ready  in  1  sink accepts the byte
out_last  out  1  marks the final byte of the stream

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, buffer empty, in-flight reads discarded.
- FSM states: IDLE, HDR, JED, DRAIN.
  - IDLE -> HDR on start.
  - HDR -> JED after read HDR_SIZE-1 is issued.
  - JED -> DRAIN when the EOI byte is captured, or when the last payload address is issued.
  - DRAIN -> IDLE when the out_last byte is accepted; done pulses in that same cycle.
- busy is high from the cycle after start up to and including the done cycle. start is ignored while busy.
- Read issue: one read per cycle, only while (buffer occupancy + in-flight reads) < BUF_DEPTH. Return data is pushed into the buffer RD_LAT cycles after issue.
- Byte order: the stream carries header bytes 0..HDR_SIZE-1 first, then payload bytes. The first byte reaches out_valid no earlier than RD_LAT+1 cycles after start.
- Handshake: out_data and out_last hold stable while out_valid && !out_ready. A push and a pop in the same cycle are allowed, including when the buffer is full.
- EOI detection: payload phase only. Uses a 16-bit shift register of captured payload bytes, seeded 0 at the start of the payload phase. An exact FF followed by D9 terminates the stream:
  - D9 is pushed with out_last=1.
  - Further issue stops.
  - In-flight reads returning after D9 are discarded, not pushed.
  - Header bytes never trigger EOI.
- Linear addressing (TILED=0): je_addr runs 0,1,2..IMG_W*IMG_H*BPP-1.
- Tiled addressing (TILED=1): address = (row*IMG_W + col)*BPP + b. Loop nesting, innermost first:
  - byte b = 0..BPP-1
  - col within tile
  - row within tile
  - tile x
  - tile y
  - Edge tiles are clipped at IMG_W and IMG_H; IMG_W and IMG_H need not be multiples of 8.
  - Counter widths are derived from $clog2 of the dimensions. The multiply is registered, and its latency is absorbed ahead of issue.
- Exhaustion: if the last payload address is read without EOI, that byte carries out_last=1 and err_overrun is set.
- Reset mid-stream: in the next cycle out_valid=0, busy=0, the buffer is flushed and in-flight returns are ignored. A following start restarts at hd_addr 0.

Optional Feature:
STREAM_LEN_EN:
- Defined: adds output port stream_len [HDR_AW+JE_AW-1:0].
  - Counts accepted bytes.
  - Latched in the done cycle and held until the next start.
  - Reset value 0.
- Undefined: the port, counter and latch are absent. All other behaviour is identical.

Decomposition:
- Package jpeg_stream_pkg holds:
  - FSM state enum
  - EOI marker constant 16'hFFD9
  - tile size constant 8
  - parameter legality checks (BUF_DEPTH >= RD_LAT+2, address widths large enough)
- One natural sub-module: jpeg_tile_addr_gen, the tiled/linear payload address counter with advance/last handshake.

Test Plan:
1. IMG_W=16, IMG_H=10, BPP=2, TILED=1, out_ready=1 -> je_addr sequence 0..15, 32..47, …, 224..239, then 16..31, 48..63, …; third tile starts at 256 and covers rows 8-9 only.
2. HDR_SIZE=4, payload 11 22 FF 00 FF D9 at addresses 0-5, out_ready=1 -> stream is 4 header bytes then 11 22 FF 00 FF D9 (10 bytes); out_last on D9; done 1 pulse; err_overrun=0.
3. Same as scenario 2 with RD_LAT=2 and out_ready low for 10 cycles then toggling every cycle -> identical byte sequence, no loss or duplication, out_data stable while stalled.
4. Payload all 00, IMG_W=16, IMG_H=10, BPP=2 -> 320 payload bytes, out_last on the 320th, err_overrun=1; the next start clears it.
5. Payload FF FF D9 -> stream terminates at D9 (index 2); reads in flight past index 2 are not emitted.
6. reset pulse while byte 6 is pending -> next cycle out_valid=0 and busy=0; a new start emits header byte 0 first. With STREAM_LEN_EN defined, stream_len=10 after scenario 2.
